// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared widths, command layout and FSM encoding for the I2C command sequencer
package i2c_seq_pkg;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int CMD_W  = 16;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;
endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: DEPTH-entry command queue with registered count
// Ports: clk/rst, push+wdata in, pop+rdata (head, valid when !empty), full, empty, count.
module i2c_cmd_fifo
   import i2c_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [CMD_W-1:0]         wdata,
   input  logic                     pop,
   output logic [CMD_W-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_q + AW'(do_push);
         rd_q    <= rd_q + AW'(do_pop);
         count_q <= count_d;
      end
      if (do_push) mem_q[wr_q] <= wdata;
   end
   assign rdata = mem_q[rd_q];
   assign full  = count_q == (AW+1)'(DEPTH);
   assign empty = count_q == '0;
   assign count = count_q;
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues I2C commands and runs them one at a time on an i2c_master
// Ports: cmd_* command stream in (valid/ready), m_* master handshake (enable out, ready in),
// rsp_* one-cycle completion strobe with read byte and timeout flag, busy status.
module i2c_cmd_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cmd_rw,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_data_in,
   output logic              m_rw,
   output logic              m_enable,
   input  logic              m_ready,
   input  logic [DATA_W-1:0] m_data_out,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy
);
   localparam int TW = $clog2(TIMEOUT);
   state_e                 state_q, state_d;
   cmd_t                   head, cmd_q, cmd_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
   logic                   full, empty, start, in_xfer, tmo_hit;
   logic [$clog2(DEPTH):0] count;
   i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (cmd_valid && cmd_ready),
      .wdata({cmd_rw, cmd_addr, cmd_data}),
      .pop  (start),
      .rdata(head),
      .full (full),
      .empty(empty),
      .count(count)
   );
   assign start   = state_q == IDLE && !empty && m_ready;
   assign in_xfer = state_q == ISSUE || state_q == WAIT;
   // timeout outranks any master handshake seen in the same cycle
   assign tmo_hit = in_xfer && tmo_q == TW'(TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         tmo_q      <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         tmo_q      <= tmo_d;
         rsp_data_q <= rsp_data_d;
      end
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = start ? ISSUE : IDLE;
         ISSUE:   state_d = tmo_hit ? IDLE : (m_ready ? ISSUE : WAIT);
         WAIT:    state_d = tmo_hit ? IDLE : (m_ready ? DONE : WAIT);
         default: state_d = IDLE;
      endcase
      cmd_d      = start ? head : cmd_q;
      // counter idles at zero, so ISSUE is always entered with a cleared count
      tmo_d      = in_xfer ? tmo_q + TW'(1) : '0;
      rsp_data_d = (state_q == WAIT && m_ready && !tmo_hit) ? (cmd_q.rw ? m_data_out : '0) : rsp_data_q;
   end
   always_comb begin
      cmd_ready = !rst && !full;
      m_addr    = cmd_q.addr;
      m_data_in = cmd_q.data;
      m_rw      = cmd_q.rw;
      m_enable  = !rst && state_q == ISSUE && !tmo_hit;
      rsp_valid = !rst && (state_q == DONE || tmo_hit);
      rsp_err   = !rst && tmo_hit;
      rsp_data  = state_q == DONE ? rsp_data_q : '0;
      busy      = !rst && (state_q != IDLE || count != '0);
   end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: scoreboard bench for i2c_cmd_sequencer with a behavioural master model
module tb_i2c_cmd_sequencer;
   logic       clk = 0, rst = 1, cmd_valid = 0, cmd_rw = 0;
   logic [6:0] cmd_addr = 0;
   logic [7:0] cmd_data = 0;
   logic       cmd_ready, m_rw, m_enable, m_ready, rsp_valid, rsp_err, busy;
   logic [6:0] m_addr;
   logic [7:0] m_data_in, m_data_out, rsp_data;
   logic       ovr = 0, ovr_val = 0, mr_model;
   logic [3:0] mcnt;
   logic [8:0] exp_q[$];
   logic [8:0] mon_e;
   int         errors = 0, checks = 0;
   i2c_cmd_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rw(cmd_rw),
      .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
      .m_ready(m_ready), .m_data_out(m_data_out),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );
   always #5 clk = ~clk;
   assign m_ready = ovr ? ovr_val : mr_model;
   // master model: busy for 4 cycles after an enable, then returns a byte derived from the address
   always @(posedge clk) begin
      if (rst) begin
         mr_model   <= 1;
         mcnt       <= 0;
         m_data_out <= 0;
      end else if (mr_model && m_enable) begin
         mr_model <= 0;
         mcnt     <= 3;
      end else if (!mr_model) begin
         if (mcnt == 0) begin
            mr_model   <= 1;
            m_data_out <= {1'b0, m_addr} ^ 8'h69;
         end else mcnt <= mcnt - 1;
      end
   end
   always @(negedge clk) begin
      if (rsp_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got err=%0b data=%h, required no response", rsp_err, rsp_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({rsp_err, rsp_data} !== mon_e) begin
               errors++;
               $display("FAIL rsp: got err=%0b data=%h, required err=%0b data=%h", rsp_err, rsp_data, mon_e[8], mon_e[7:0]);
            end
         end
      end
   end
   function automatic logic [8:0] exp_of(input logic [6:0] a, input logic rw);
      return rw ? {1'b0, {1'b0, a} ^ 8'h69} : 9'h000;
   endfunction
   task automatic send(input logic [6:0] a, input logic [7:0] d, input logic rw, input logic [8:0] e);
      int n = 0;
      cmd_addr = a; cmd_data = d; cmd_rw = rw; cmd_valid = 1;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL send_accept: got cmd_ready=0 for 100 cycles, required 1");
      end else begin
         @(posedge clk);
         exp_q.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 0;
   endtask
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
   endtask
   task automatic test_reset();
      rst = 1;
      repeat (3) @(negedge clk);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++; if (m_enable !== 1'b0) begin errors++; $display("FAIL reset_en: got %b, required 0", m_enable); end
      checks++; if ({m_rw, m_addr, m_data_in} !== 16'h0) begin errors++; $display("FAIL reset_mcmd: got %h, required 0000", {m_rw, m_addr, m_data_in}); end
      checks++; if ({rsp_valid, rsp_err, rsp_data} !== 10'h0) begin errors++; $display("FAIL reset_rsp: got %h, required 000", {rsp_valid, rsp_err, rsp_data}); end
      rst = 0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, required 1", cmd_ready); end
   endtask
   task automatic test_write();
      send(7'h55, 8'hAA, 0, 9'h000);
      checks++; if (m_enable !== 1'b0) begin errors++; $display("FAIL latency_early: got m_enable=%b, required 0", m_enable); end
      repeat (2) @(negedge clk);
      checks++; if (m_enable !== 1'b1) begin errors++; $display("FAIL latency_en: got m_enable=%b, required 1", m_enable); end
      checks++; if ({m_rw, m_addr, m_data_in} !== {1'b0, 7'h55, 8'hAA}) begin errors++; $display("FAIL write_mcmd: got %h, required 55aa", {m_rw, m_addr, m_data_in}); end
      drain();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL write_drain: got %0d pending, required 0", exp_q.size()); end
   endtask
   task automatic test_read();
      send(7'h55, 8'h00, 1, {1'b0, 8'h3C});
      drain();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL read_drain: got %0d pending, required 0", exp_q.size()); end
   endtask
   task automatic test_fill();
      int  acc = 0;
      logic rdy;
      ovr = 1; ovr_val = 0;
      cmd_valid = 1; cmd_rw = 1; cmd_data = 8'h00;
      for (int i = 0; i < 6; i++) begin
         cmd_addr = 7'(16 + acc);
         rdy = cmd_ready;
         @(posedge clk);
         if (rdy) begin exp_q.push_back(exp_of(cmd_addr, 1)); acc++; end
         @(negedge clk);
      end
      cmd_valid = 0;
      checks++; if (acc != 4) begin errors++; $display("FAIL fill_accepts: got %0d, required 4", acc); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b, required 0", cmd_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy: got %b, required 1", busy); end
      ovr = 0;
      drain();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fill_drain: got %0d pending, required 0", exp_q.size()); end
   endtask
   task automatic test_timeout();
      int n = 0;
      ovr = 1; ovr_val = 1;
      send(7'h22, 8'h11, 0, 9'h100);
      while (!m_enable && n < 20) begin @(negedge clk); n++; end
      checks++; if (m_enable !== 1'b1) begin errors++; $display("FAIL tmo_issue: got m_enable=%b, required 1", m_enable); end
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 14) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_early: got rsp_valid=%b at 14, required 0", rsp_valid); end
         end
         if (i == 15) begin
            checks++; if ({rsp_valid, rsp_err, m_enable} !== 3'b110) begin errors++; $display("FAIL tmo_fire: got valid/err/en=%b, required 110", {rsp_valid, rsp_err, m_enable}); end
         end
      end
      ovr = 0;
      send(7'h23, 8'h44, 0, 9'h000);
      drain();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tmo_next: got %0d pending, required 0", exp_q.size()); end
   endtask
   task automatic test_reset_wait();
      int n = 0;
      send(7'h30, 8'h00, 1, exp_of(7'h30, 1));
      while (!m_enable && n < 20) begin @(negedge clk); n++; end
      checks++; if (m_enable !== 1'b1) begin errors++; $display("FAIL rw_issue: got m_enable=%b, required 1", m_enable); end
      ovr = 1; ovr_val = 0;
      send(7'h31, 8'h01, 0, 9'h000);
      send(7'h32, 8'h02, 0, 9'h000);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy: got %b, required 1", busy); end
      rst = 1;
      exp_q.delete();
      @(negedge clk);
      checks++; if ({cmd_ready, m_enable} !== 2'b00) begin errors++; $display("FAIL rw_in_reset: got ready/en=%b, required 00", {cmd_ready, m_enable}); end
      rst = 0;
      ovr = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy_after: got %b, required 0", busy); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rw_ready_after: got %b, required 1", cmd_ready); end
      repeat (20) @(negedge clk);
   endtask
   task automatic test_back_to_back();
      send(7'h41, 8'h5A, 0, exp_of(7'h41, 0));
      send(7'h42, 8'h00, 1, exp_of(7'h42, 1));
      send(7'h43, 8'h00, 1, exp_of(7'h43, 1));
      send(7'h44, 8'hC3, 0, exp_of(7'h44, 0));
      drain();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
   endtask
   initial begin
      test_reset();
      test_write();
      test_read();
      test_fill();
      test_timeout();
      test_reset_wait();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500000, required earlier finish");
      $fatal(1);
   end
endmodule
